misc_pipe: RTL and testbench

Parametrised successor to the combinational misc execution unit. Resolves JAL, JALR, LUI and AUIPC, and flags illegal or misaligned-target instructions as exceptions. Results are registered into a DEPTH-entry result queue with valid/ready handshakes on both sides. Sits between the issue stage and writeback/branch-resolve, and honours pipeline flush.

---
 rtl/misc_pipe.sv | 196 +++++++++++++++++++
 tb/tb_misc_pipe.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/misc_pipe.sv
// misc_pipe: registered misc execution unit for JAL, JALR, LUI and AUIPC.
//
// Each accepted op is resolved combinationally into a link value, a redirect
// and an exception record. That record is written into a DEPTH-entry FIFO,
// so a result is visible on out_* one cycle after acceptance at the earliest.
//
// Ports
//   clk, rst                  clock; synchronous active-low reset
//   flush                     drop queued results and refuse same-cycle input
//   in_valid / in_ready       issue-side handshake
//   in_op                     0 INVAL, 1 JALR, 2 LUI, 3 AUIPC, 4 JAL, 5-7 INVAL
//   in_pc, in_rs1_val, in_imm operands (imm already sign-extended/shifted)
//   in_rd, in_compressed      destination index; 16-bit instruction flag
//   out_valid / out_ready     writeback-side handshake
//   out_rd_idx, out_rd_val    writeback (index 0 = no write)
//   out_br_valid/_target      redirect request
//   out_exc_valid/_cause/_tval exception (cause 0 misaligned, 2 illegal)
module misc_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned C_EXT = 1,
  parameter int unsigned REG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_rs1_val,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [REG_W-1:0] in_rd,
  input  logic             in_compressed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [REG_W-1:0] out_rd_idx,
  output logic [XLEN-1:0]  out_rd_val,
  output logic             out_br_valid,
  output logic [XLEN-1:0]  out_br_target,
  output logic             out_exc_valid,
  output logic [3:0]       out_exc_cause,
  output logic [XLEN-1:0]  out_exc_tval
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CW   = PW + 1;
  localparam bit          C_ON = (C_EXT != 0);

  typedef enum logic [2:0] {
    OP_INVAL = 3'd0,
    OP_JALR  = 3'd1,
    OP_LUI   = 3'd2,
    OP_AUIPC = 3'd3,
    OP_JAL   = 3'd4
  } op_e;

  typedef struct packed {
    logic [REG_W-1:0] rd_idx;
    logic [XLEN-1:0]  rd_val;
    logic             br_valid;
    logic [XLEN-1:0]  br_target;
    logic             exc_valid;
    logic [3:0]       exc_cause;
    logic [XLEN-1:0]  exc_tval;
  } res_t;

  // ---------------------------------------------------------------------------
  // Result computation
  // ---------------------------------------------------------------------------
  op_e             op;
  logic [XLEN-1:0] step;
  logic [XLEN-1:0] link;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] tgt;
  logic [XLEN-1:0] val;
  logic            is_br;
  logic            legal;
  res_t            res_d;

  assign op = op_e'(in_op);

  always_comb begin
    step     = in_compressed ? XLEN'(2) : XLEN'(4);
    link     = in_pc + step;
    jalr_sum = in_rs1_val + in_imm;
    tgt      = '0;
    val      = '0;
    is_br    = 1'b0;
    // A 16-bit encoding is only legal when the C extension is present.
    legal    = !(in_compressed && !C_ON);

    case (op)
      OP_JALR: begin
        tgt   = {jalr_sum[XLEN-1:1], 1'b0};
        val   = link;
        is_br = 1'b1;
      end
      OP_JAL: begin
        tgt   = in_pc + in_imm;
        val   = link;
        is_br = 1'b1;
      end
      OP_LUI:   val = in_imm;
      OP_AUIPC: val = in_pc + in_imm;
      default:  legal = 1'b0;
    endcase

    // Exceptions suppress writeback and redirect entirely.
    res_d = '0;
    if (!legal) begin
      res_d.exc_valid = 1'b1;
      res_d.exc_cause = 4'd2;
    end else if (is_br && !C_ON && tgt[1]) begin
      res_d.exc_valid = 1'b1;
      res_d.exc_cause = 4'd0;
      res_d.exc_tval  = tgt;
    end else begin
      res_d.br_valid  = is_br;
      res_d.br_target = tgt;
      if (in_rd != '0) begin
        res_d.rd_idx = in_rd;
        res_d.rd_val = val;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result FIFO
  // ---------------------------------------------------------------------------
  res_t          mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push;
  logic          pop;
  res_t          head;

  assign out_valid = (count_q != '0);
  // A full queue still accepts when the head leaves in the same cycle.
  assign in_ready  = rst && !flush && ((count_q < CW'(DEPTH)) || out_ready);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= res_d;
    end
  end

  always_comb begin
    head = '0;
    if (out_valid) begin
      head = mem_q[rd_ptr_q];
    end
  end

  assign out_rd_idx    = head.rd_idx;
  assign out_rd_val    = head.rd_val;
  assign out_br_valid  = head.br_valid;
  assign out_br_target = head.br_target;
  assign out_exc_valid = head.exc_valid;
  assign out_exc_cause = head.exc_cause;
  assign out_exc_tval  = head.exc_tval;

endmodule

// File: tb/tb_misc_pipe.sv
// Testbench for misc_pipe. Two instances share all inputs: u_c has the C
// extension enabled, u_nc has it disabled, so each stimulus exercises both
// alignment/legality rule sets. Expected values come from constants and from
// a reference function written directly from the instruction semantics.
module tb_misc_pipe;

  typedef struct packed {
    logic [4:0]  rd_idx;
    logic [31:0] rd_val;
    logic        br_valid;
    logic [31:0] br_target;
    logic        exc_valid;
    logic [3:0]  cause;
    logic [31:0] tval;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [2:0]  in_op;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_val;
  logic [31:0] in_imm;
  logic [4:0]  in_rd;
  logic        in_compressed;
  logic        out_ready;

  logic        c_in_ready, c_out_valid, c_br_valid, c_exc_valid;
  logic [4:0]  c_rd_idx;
  logic [31:0] c_rd_val, c_br_target, c_exc_tval;
  logic [3:0]  c_exc_cause;
  logic        n_in_ready, n_out_valid, n_br_valid, n_exc_valid;
  logic [4:0]  n_rd_idx;
  logic [31:0] n_rd_val, n_br_target, n_exc_tval;
  logic [3:0]  n_exc_cause;

  exp_t obs_c, obs_n;
  assign obs_c = {c_rd_idx, c_rd_val, c_br_valid, c_br_target, c_exc_valid, c_exc_cause, c_exc_tval};
  assign obs_n = {n_rd_idx, n_rd_val, n_br_valid, n_br_target, n_exc_valid, n_exc_cause, n_exc_tval};

  int unsigned tests;
  int unsigned fails;

  misc_pipe #(.XLEN(32), .DEPTH(2), .C_EXT(1), .REG_W(5)) u_c (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(c_in_ready), .in_op(in_op), .in_pc(in_pc),
    .in_rs1_val(in_rs1_val), .in_imm(in_imm), .in_rd(in_rd), .in_compressed(in_compressed),
    .out_valid(c_out_valid), .out_ready(out_ready), .out_rd_idx(c_rd_idx), .out_rd_val(c_rd_val),
    .out_br_valid(c_br_valid), .out_br_target(c_br_target), .out_exc_valid(c_exc_valid),
    .out_exc_cause(c_exc_cause), .out_exc_tval(c_exc_tval)
  );

  misc_pipe #(.XLEN(32), .DEPTH(2), .C_EXT(0), .REG_W(5)) u_nc (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(n_in_ready), .in_op(in_op), .in_pc(in_pc),
    .in_rs1_val(in_rs1_val), .in_imm(in_imm), .in_rd(in_rd), .in_compressed(in_compressed),
    .out_valid(n_out_valid), .out_ready(out_ready), .out_rd_idx(n_rd_idx), .out_rd_val(n_rd_val),
    .out_br_valid(n_br_valid), .out_br_target(n_br_target), .out_exc_valid(n_exc_valid),
    .out_exc_cause(n_exc_cause), .out_exc_tval(n_exc_tval)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [4:0] rd, input logic [31:0] val, input logic br,
                              input logic [31:0] tgt, input logic exc, input logic [3:0] cause,
                              input logic [31:0] tval);
    return {rd, val, br, tgt, exc, cause, tval};
  endfunction

  // Reference semantics: link = pc + instruction size, JALR clears bit 0,
  // exceptions wipe every other field, rd 0 discards the link value.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] pc,
                                 input logic [31:0] rs1, input logic [31:0] imm,
                                 input logic [4:0] rd, input logic comp, input logic cext);
    logic [31:0] link, tgt, val;
    logic        br, legal;
    link  = pc + (comp ? 32'd2 : 32'd4);
    legal = !(comp && !cext);
    br    = 1'b0;
    tgt   = 32'd0;
    val   = 32'd0;
    case (op)
      3'd1: begin tgt = (rs1 + imm) & 32'hFFFF_FFFE; val = link; br = 1'b1; end
      3'd4: begin tgt = pc + imm; val = link; br = 1'b1; end
      3'd2: val = imm;
      3'd3: val = pc + imm;
      default: legal = 1'b0;
    endcase
    if (!legal) return mk(5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 4'd2, 32'd0);
    if (br && !cext && tgt[1]) return mk(5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 4'd0, tgt);
    return mk(rd, (rd == 5'd0) ? 32'd0 : val, br, tgt, 1'b0, 4'd0, 32'd0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [2:0] op, input logic [31:0] pc, input logic [31:0] rs1,
                        input logic [31:0] imm, input logic [4:0] rd, input logic comp);
    in_op = op; in_pc = pc; in_rs1_val = rs1; in_imm = imm; in_rd = rd; in_compressed = comp;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    set_op(3'd2, 32'h0, 32'h0, 32'h5000, 5'd1, 1'b0);
    tick();
    tests++;
    if (c_in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b expected 0", c_in_ready); end
    tests++;
    if (c_out_valid !== 1'b0 || n_out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_out_valid: got %b/%b expected 0/0", c_out_valid, n_out_valid);
    end
    tests++;
    if (obs_c !== '0) begin fails++; $display("FAIL reset_fields: got %h expected 0", obs_c); end
    rst = 1'b1; in_valid = 1'b0;
    tick();
    tests++;
    if (c_out_valid !== 1'b0) begin fails++; $display("FAIL reset_no_accept: got out_valid %b expected 0", c_out_valid); end
  endtask

  task automatic test_jalr();
    out_ready = 1'b1; in_valid = 1'b1;
    set_op(3'd1, 32'h1000, 32'h2003, 32'h4, 5'd1, 1'b0);
    #1;
    tests++;
    if (c_in_ready !== 1'b1) begin fails++; $display("FAIL jalr_in_ready: got %b expected 1", c_in_ready); end
    tick();
    in_valid = 1'b0;
    tests++;
    if (c_out_valid !== 1'b1 || obs_c !== mk(5'd1, 32'h1004, 1'b1, 32'h2006, 1'b0, 4'd0, 32'd0)) begin
      fails++; $display("FAIL jalr_c: got v=%b %h expected v=1 %h", c_out_valid, obs_c,
                        mk(5'd1, 32'h1004, 1'b1, 32'h2006, 1'b0, 4'd0, 32'd0));
    end
    tests++;
    if (obs_n !== mk(5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 4'd0, 32'h2006)) begin
      fails++; $display("FAIL jalr_misaligned_nc: got %h expected %h", obs_n,
                        mk(5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 4'd0, 32'h2006));
    end
    tick();
    tests++;
    if (c_out_valid !== 1'b0) begin fails++; $display("FAIL jalr_drain: got out_valid %b expected 0", c_out_valid); end
  endtask

  task automatic test_jal();
    out_ready = 1'b1; in_valid = 1'b1;
    set_op(3'd4, 32'h100, 32'h0, 32'h20, 5'd1, 1'b1);
    tick();
    set_op(3'd4, 32'h0, 32'h0, 32'h6, 5'd3, 1'b0);
    tests++;
    if (obs_c !== mk(5'd1, 32'h102, 1'b1, 32'h120, 1'b0, 4'd0, 32'd0)) begin
      fails++; $display("FAIL jal_compressed_c: got %h expected %h", obs_c, mk(5'd1, 32'h102, 1'b1, 32'h120, 1'b0, 4'd0, 32'd0));
    end
    tests++;
    if (obs_n !== mk(5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 4'd2, 32'd0)) begin
      fails++; $display("FAIL jal_compressed_illegal_nc: got %h expected %h", obs_n, mk(5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 4'd2, 32'd0));
    end
    tick();
    set_op(3'd2, 32'h0, 32'h0, 32'h1234_5000, 5'd0, 1'b0);
    tests++;
    if (obs_n !== mk(5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 4'd0, 32'h6)) begin
      fails++; $display("FAIL jal_misaligned_nc: got %h expected %h", obs_n, mk(5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 4'd0, 32'h6));
    end
    tests++;
    if (obs_c !== mk(5'd3, 32'h4, 1'b1, 32'h6, 1'b0, 4'd0, 32'd0)) begin
      fails++; $display("FAIL jal_aligned_c: got %h expected %h", obs_c, mk(5'd3, 32'h4, 1'b1, 32'h6, 1'b0, 4'd0, 32'd0));
    end
    tick();
    set_op(3'd6, 32'h0, 32'h0, 32'h0, 5'd7, 1'b0);
    tests++;
    if (c_out_valid !== 1'b1 || obs_c !== '0 || obs_n !== '0) begin
      fails++; $display("FAIL lui_rd0: got v=%b %h/%h expected v=1 all zero", c_out_valid, obs_c, obs_n);
    end
    tick();
    in_valid = 1'b0;
    tests++;
    if (obs_c !== mk(5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 4'd2, 32'd0)) begin
      fails++; $display("FAIL op6_illegal_c: got %h expected %h", obs_c, mk(5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 4'd2, 32'd0));
    end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0; in_valid = 1'b1;
    set_op(3'd3, 32'h10, 32'h0, 32'h1000, 5'd2, 1'b0);
    tick();
    set_op(3'd2, 32'h0, 32'h0, 32'h00AB_C000, 5'd3, 1'b0);
    tick();
    set_op(3'd4, 32'h40, 32'h0, 32'h8, 5'd4, 1'b0);
    #1;
    tests++;
    if (c_in_ready !== 1'b0) begin fails++; $display("FAIL full_in_ready: got %b expected 0", c_in_ready); end
    tick();
    tests++;
    if (c_rd_val !== 32'h1010 || c_rd_idx !== 5'd2) begin
      fails++; $display("FAIL held_head: got rd%0d=%h expected rd2=00001010", c_rd_idx, c_rd_val);
    end
    out_ready = 1'b1;
    #1;
    tests++;
    if (c_in_ready !== 1'b1) begin fails++; $display("FAIL full_pop_in_ready: got %b expected 1", c_in_ready); end
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    tests++;
    if (c_in_ready !== 1'b0 || c_rd_val !== 32'h00AB_C000) begin
      fails++; $display("FAIL push_pop_full: got in_ready=%b head=%h expected 0 and 00abc000", c_in_ready, c_rd_val);
    end
    out_ready = 1'b1;
    tick();
    tests++;
    if (obs_c !== mk(5'd4, 32'h44, 1'b1, 32'h48, 1'b0, 4'd0, 32'd0)) begin
      fails++; $display("FAIL fifo_third: got %h expected %h", obs_c, mk(5'd4, 32'h44, 1'b1, 32'h48, 1'b0, 4'd0, 32'd0));
    end
    tick();
    tests++;
    if (c_out_valid !== 1'b0) begin fails++; $display("FAIL fifo_empty: got out_valid %b expected 0", c_out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    set_op(3'd2, 32'h0, 32'h0, 32'h7000, 5'd5, 1'b0);
    tick();
    tick();
    flush = 1'b1;
    #1;
    tests++;
    if (c_in_ready !== 1'b0) begin fails++; $display("FAIL flush_in_ready: got %b expected 0", c_in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    tests++;
    if (c_out_valid !== 1'b0 || c_in_ready !== 1'b1) begin
      fails++; $display("FAIL flush_after: got out_valid=%b in_ready=%b expected 0/1", c_out_valid, c_in_ready);
    end
    tick();
    tests++;
    if (c_out_valid !== 1'b0) begin fails++; $display("FAIL flush_not_accepted: got out_valid %b expected 0", c_out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1;
    set_op(3'd3, 32'h200, 32'h0, 32'h300, 5'd6, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    tests++;
    if (c_in_ready !== 1'b0) begin fails++; $display("FAIL midreset_in_ready: got %b expected 0", c_in_ready); end
    tick();
    rst = 1'b1; in_valid = 1'b0;
    tests++;
    if (c_out_valid !== 1'b0 || obs_c !== '0 || obs_n !== '0) begin
      fails++; $display("FAIL midreset_out: got v=%b %h/%h expected 0 and zeros", c_out_valid, obs_c, obs_n);
    end
  endtask

  task automatic test_random();
    exp_t qc[$];
    exp_t qn[$];
    logic exp_ready;
    for (int i = 0; i < 500; i++) begin
      flush     = ($urandom_range(0, 15) == 0);
      in_valid  = $urandom_range(0, 1) == 1;
      out_ready = $urandom_range(0, 3) != 0;
      set_op(3'($urandom_range(0, 7)), $urandom & 32'hFFFF_FFFE, $urandom, $urandom,
             ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom_range(0, 1) == 1);
      #1;
      exp_ready = !flush && (qc.size() < 2 || out_ready);
      tests++;
      if (c_in_ready !== exp_ready || n_in_ready !== exp_ready) begin
        fails++; $display("FAIL rand_in_ready[%0d]: got %b/%b expected %b", i, c_in_ready, n_in_ready, exp_ready);
      end
      tests++;
      if (c_out_valid !== (qc.size() != 0) || n_out_valid !== (qn.size() != 0)) begin
        fails++; $display("FAIL rand_out_valid[%0d]: got %b/%b expected %0d", i, c_out_valid, n_out_valid, qc.size());
      end
      if (qc.size() != 0) begin
        tests++;
        if (obs_c !== qc[0] || obs_n !== qn[0]) begin
          fails++; $display("FAIL rand_data[%0d]: got %h / %h expected %h / %h", i, obs_c, obs_n, qc[0], qn[0]);
        end
      end
      if (flush) begin
        qc.delete();
        qn.delete();
      end else begin
        if (qc.size() != 0 && out_ready) begin
          void'(qc.pop_front());
          void'(qn.pop_front());
        end
        if (in_valid && exp_ready) begin
          qc.push_back(model(in_op, in_pc, in_rs1_val, in_imm, in_rd, in_compressed, 1'b1));
          qn.push_back(model(in_op, in_pc, in_rs1_val, in_imm, in_rd, in_compressed, 1'b0));
        end
      end
      tick();
    end
    in_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    #1;
    test_reset();
    test_jalr();
    test_jal();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
